// File: rtl/pipe_ctrl_n_if.sv
// Fetch-side instruction stream into the pipeline sequencer and the
// write-back stream out of its last stage.
interface pipe_ctrl_n_if #(
    parameter int PAYLOAD_W = 32,
    parameter int REG_AW    = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [REG_AW-1:0]    in_rs;
    logic [REG_AW-1:0]    in_rt;
    logic [REG_AW-1:0]    in_rd;
    logic                 in_wen;
    logic                 in_is_load;

    logic                 out_valid;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [REG_AW-1:0]    out_rd;
    logic                 out_wen;

    modport master (
        output in_valid, in_payload, in_rs, in_rt, in_rd, in_wen, in_is_load,
        input  in_ready,
        input  out_valid, out_payload, out_rd, out_wen
    );

    modport slave (
        input  in_valid, in_payload, in_rs, in_rt, in_rd, in_wen, in_is_load,
        output in_ready,
        output out_valid, out_payload, out_rd, out_wen
    );
endinterface

// File: rtl/pipe_ctrl_n.sv
// Generic in-order pipeline sequencer: inter-stage registers, load-use
// bubble insertion, forwarding selects, global hold, flush and counters.
module pipe_ctrl_n #(
    parameter int STAGES      = 5,
    parameter int PAYLOAD_W   = 32,
    parameter int REG_AW      = 5,
    parameter int LOAD_SHADOW = 1,
    parameter int FW          = $clog2(STAGES)
) (
    input  logic              clk,
    input  logic              reset,
    pipe_ctrl_n_if.slave      bus,
    input  logic              flush,
    input  logic              hold,
    output logic [FW-1:0]     fwd_a,
    output logic [FW-1:0]     fwd_b,
    output logic [STAGES-1:0] stage_valid,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    typedef struct packed {
        logic                 valid;
        logic [PAYLOAD_W-1:0] payload;
        logic [REG_AW-1:0]    rs;
        logic [REG_AW-1:0]    rt;
        logic [REG_AW-1:0]    rd;
        logic                 wen;
        logic                 is_load;
    } stage_t;

    stage_t st [STAGES];
    stage_t fetch;
    stage_t bubble;
    logic   load_use;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        load_use = 1'b0;
        for (int k = 1; k <= LOAD_SHADOW; k++) begin
            if (st[k].valid && st[k].is_load && st[k].wen && st[k].rd != '0 &&
                (st[k].rd == st[0].rs || st[k].rd == st[0].rt))
                load_use = 1'b1;
        end
        load_use = load_use && st[0].valid;
    end

    // Walk from the oldest stage down so the youngest eligible producer wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = STAGES - 1; k > LOAD_SHADOW; k--) begin
            if (st[0].valid && st[k].valid && st[k].wen && st[k].rd != '0) begin
                if (st[k].rd == st[0].rs) fwd_a = FW'(k);
                if (st[k].rd == st[0].rt) fwd_b = FW'(k);
            end
        end
    end

    always_comb begin
        fetch = '{valid: bus.in_valid, payload: bus.in_payload, rs: bus.in_rs,
                  rt: bus.in_rt, rd: bus.in_rd, wen: bus.in_wen,
                  is_load: bus.in_is_load};
        bubble       = st[0];
        bubble.valid = 1'b0;
        bubble.wen   = 1'b0;
    end

    always_comb begin
        stage_valid = '0;
        for (int k = 0; k < STAGES; k++) stage_valid[k] = st[k].valid;
    end

    assign bus.in_ready    = !hold && !flush && !load_use;
    assign bus.out_valid   = st[STAGES-1].valid;
    assign bus.out_payload = st[STAGES-1].payload;
    assign bus.out_rd      = st[STAGES-1].rd;
    assign bus.out_wen     = st[STAGES-1].valid && st[STAGES-1].wen;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // stage samples its neighbour's pre-edge value regardless of loop order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the stage array is reset field by field (payload and
            // indices included) because reset must discard all in-flight work.
            for (int k = 0; k < STAGES; k++) st[k] <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (hold) begin
            // A flush arriving during hold still kills stage 0.
            if (flush) begin
                st[0].valid <= 1'b0;
                if (st[0].valid) flush_cnt <= sat_inc(flush_cnt);
            end
        end else begin
            for (int k = STAGES - 1; k >= 2; k--) st[k] <= st[k-1];
            if (flush) begin
                st[1]       <= bubble;
                st[0].valid <= 1'b0;
                if (st[0].valid) flush_cnt <= sat_inc(flush_cnt);
            end else if (load_use) begin
                st[1]     <= bubble;
                stall_cnt <= sat_inc(stall_cnt);
            end else begin
                st[1] <= st[0];
                st[0] <= fetch;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Scoreboard bench for pipe_ctrl_n: directed hazard/flush/hold/reset cases
// followed by a long randomized run against a queue-based reference model.
module tb_pipe_ctrl_n;
    localparam int S   = 5;
    localparam int LS  = 1;
    localparam int PW  = 32;
    localparam int AW  = 5;
    localparam int FWW = $clog2(S);

    typedef struct {
        logic          v;
        logic [PW-1:0] pay;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] rd;
        logic          wen;
        logic          ld;
    } ins_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           flush = 1'b0;
    logic           hold = 1'b0;
    logic [FWW-1:0] fwd_a, fwd_b;
    logic [S-1:0]   stage_valid;
    logic [15:0]    stall_cnt, flush_cnt;

    pipe_ctrl_n_if #(.PAYLOAD_W(PW), .REG_AW(AW)) bus ();

    pipe_ctrl_n #(.STAGES(S), .PAYLOAD_W(PW), .REG_AW(AW), .LOAD_SHADOW(LS)) dut (
        .clk(clk), .reset(reset), .bus(bus), .flush(flush), .hold(hold),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stage_valid(stage_valid),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    int   seq = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    ins_t pipe[$];
    ins_t exp_q[$];
    ins_t idle_i;
    int   acc_cyc[logic [PW-1:0]];
    int   out_cyc[logic [PW-1:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ins_t mk(input int rs, input int rt, input int rd, input bit wen, input bit ld);
        ins_t r;
        seq++;
        r.v   = 1'b1;
        r.pay = PW'(seq) | (PW'($urandom_range(0, 255)) << 24);
        r.rs  = AW'(rs);
        r.rt  = AW'(rt);
        r.rd  = AW'(rd);
        r.wen = wen;
        r.ld  = ld;
        return r;
    endfunction

    function automatic void m_clear();
        pipe.delete();
        repeat (S) pipe.push_back(idle_i);
        exp_q.delete();
        m_stall = 0;
        m_flush = 0;
    endfunction

    // Reference rules: a load still in its shadow blocks a dependent decode.
    function automatic bit m_load_use();
        if (!pipe[0].v) return 1'b0;
        for (int k = 1; k <= LS; k++)
            if (pipe[k].v && pipe[k].ld && pipe[k].wen && pipe[k].rd != 0 &&
                (pipe[k].rd == pipe[0].rs || pipe[k].rd == pipe[0].rt))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_fwd(input logic [AW-1:0] r);
        if (!pipe[0].v) return 0;
        for (int k = LS + 1; k < S; k++)
            if (pipe[k].v && pipe[k].wen && pipe[k].rd != 0 && pipe[k].rd == r)
                return k;
        return 0;
    endfunction

    task automatic cycle(input ins_t in, input bit fl, input bit hd);
        bit           lu;
        logic [S-1:0] sv;
        ins_t         t;
        @(negedge clk);
        bus.in_valid   = in.v;
        bus.in_payload = in.pay;
        bus.in_rs      = in.rs;
        bus.in_rt      = in.rt;
        bus.in_rd      = in.rd;
        bus.in_wen     = in.wen;
        bus.in_is_load = in.ld;
        flush = fl;
        hold  = hd;
        #1;
        lu = m_load_use();
        for (int k = 0; k < S; k++) sv[k] = pipe[k].v;
        check("in_ready", bus.in_ready, !hd && !fl && !lu);
        check("fwd_a", fwd_a, m_fwd(pipe[0].rs));
        check("fwd_b", fwd_b, m_fwd(pipe[0].rt));
        check("stage_valid", stage_valid, sv);
        check("out_valid", bus.out_valid, pipe[S-1].v);
        check("stall_cnt", stall_cnt, (m_stall > 65535) ? 65535 : m_stall);
        check("flush_cnt", flush_cnt, (m_flush > 65535) ? 65535 : m_flush);
        if (fl && pipe[0].v) begin
            m_flush++;
            void'(exp_q.pop_back());
        end
        if (hd) begin
            if (fl) begin
                t = pipe[0]; t.v = 1'b0; pipe[0] = t;
            end
        end else if (fl) begin
            t = pipe[0]; t.v = 1'b0; pipe[0] = t;
            pipe.push_front(t);
            void'(pipe.pop_back());
        end else if (lu) begin
            m_stall++;
            t = pipe[0]; t.v = 1'b0;
            pipe.insert(1, t);
            void'(pipe.pop_back());
        end else begin
            pipe.push_front(in);
            void'(pipe.pop_back());
            if (in.v) begin
                exp_q.push_back(in);
                acc_cyc[in.pay] = cyc;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) cycle(idle_i, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        flush = 1'b0;
        hold  = 1'b0;
        reset = 1'b0;
        #1;
        check("rst_stage_valid", stage_valid, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_wen", bus.out_wen, 0);
        check("rst_in_ready", bus.in_ready, 1);
        m_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: an output retires on a cycle where it is presented without hold.
    initial begin
        ins_t e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.out_valid && !hold) begin
                if (exp_q.size() == 0) begin
                    check("out_spurious", bus.out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_payload", bus.out_payload, e.pay);
                    check("out_rd", bus.out_rd, e.rd);
                    check("out_wen", bus.out_wen, e.wen);
                    out_cyc[bus.out_payload] = cyc;
                end
            end
        end
    end

    function automatic int delay_of(input logic [PW-1:0] p);
        return out_cyc.exists(p) ? out_cyc[p] - acc_cyc[p] : -1;
    endfunction

    initial begin
        ins_t p1[8];
        ins_t a, b, c, d;
        idle_i = '{v: 1'b0, pay: '0, rs: '0, rt: '0, rd: '0, wen: 1'b0, ld: 1'b0};
        bus.in_valid = 1'b0; bus.in_payload = '0; bus.in_rs = '0; bus.in_rt = '0;
        bus.in_rd = '0; bus.in_wen = 1'b0; bus.in_is_load = 1'b0;
        m_clear();

        // Back-to-back independent instructions.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            p1[i] = mk(0, 0, i + 1, 1'b1, 1'b0);
            cycle(p1[i], 1'b0, 1'b0);
        end
        idle_cycles(S + 3);
        for (int i = 0; i < 8; i++) check("b2b_latency", delay_of(p1[i].pay), S);
        check("b2b_stall_cnt", stall_cnt, 0);

        // Load then dependent add: one bubble, then forward from stage 2.
        do_reset();
        cycle(mk(0, 0, 3, 1'b1, 1'b1), 1'b0, 1'b0);
        cycle(mk(3, 0, 5, 1'b1, 1'b0), 1'b0, 1'b0);
        cycle(idle_i, 1'b0, 1'b0);
        check("lu_ready_low", bus.in_ready, 0);
        cycle(idle_i, 1'b0, 1'b0);
        check("lu_ready_back", bus.in_ready, 1);
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_fwd_a", fwd_a, 2);
        idle_cycles(S + 2);

        // ALU producer two ahead forwards both operands; rd=0 never forwards.
        do_reset();
        cycle(mk(0, 0, 4, 1'b1, 1'b0), 1'b0, 1'b0);
        cycle(mk(1, 2, 6, 1'b1, 1'b0), 1'b0, 1'b0);
        cycle(mk(4, 4, 7, 1'b1, 1'b0), 1'b0, 1'b0);
        cycle(idle_i, 1'b0, 1'b0);
        check("alu_fwd_a", fwd_a, 2);
        check("alu_fwd_b", fwd_b, 2);
        idle_cycles(S + 2);
        cycle(mk(0, 0, 0, 1'b1, 1'b0), 1'b0, 1'b0);
        cycle(mk(1, 2, 6, 1'b1, 1'b0), 1'b0, 1'b0);
        cycle(mk(0, 0, 5, 1'b1, 1'b0), 1'b0, 1'b0);
        cycle(idle_i, 1'b0, 1'b0);
        check("zero_fwd_a", fwd_a, 0);
        check("zero_fwd_b", fwd_b, 0);
        idle_cycles(S + 2);

        // Flush wins over a pending load-use.
        do_reset();
        cycle(mk(0, 0, 3, 1'b1, 1'b1), 1'b0, 1'b0);
        cycle(mk(3, 3, 5, 1'b1, 1'b0), 1'b0, 1'b0);
        cycle(idle_i, 1'b1, 1'b0);
        cycle(idle_i, 1'b0, 1'b0);
        check("fl_flush_cnt", flush_cnt, 1);
        check("fl_stall_cnt", stall_cnt, 0);
        check("fl_stage0", stage_valid[0], 0);
        idle_cycles(S + 2);

        // Three held cycles with a flush pulse inside the hold.
        do_reset();
        a = mk(0, 0, 1, 1'b1, 1'b0);
        b = mk(0, 0, 2, 1'b1, 1'b0);
        c = mk(0, 0, 3, 1'b1, 1'b0);
        d = mk(0, 0, 4, 1'b1, 1'b0);
        cycle(a, 1'b0, 1'b0);
        cycle(b, 1'b0, 1'b0);
        cycle(c, 1'b0, 1'b0);
        cycle(idle_i, 1'b0, 1'b1);
        cycle(idle_i, 1'b1, 1'b1);
        cycle(idle_i, 1'b0, 1'b1);
        cycle(d, 1'b0, 1'b0);
        idle_cycles(S + 3);
        check("hold_delay_a", delay_of(a.pay), S + 3);
        check("hold_delay_b", delay_of(b.pay), S + 3);
        check("hold_killed_c", out_cyc.exists(c.pay), 0);
        check("hold_delay_d", delay_of(d.pay), S);
        check("hold_flush_cnt", flush_cnt, 1);

        // Reset with work in flight discards everything.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(mk(0, 0, i + 1, 1'b1, 1'b0), 1'b0, 1'b0);
        do_reset();
        idle_cycles(S + 3);

        // Randomized run with dense register reuse to provoke hazards.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ins_t r;
            r = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3);
            r.v = ($urandom_range(0, 9) < 8);
            cycle(r, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end
        idle_cycles(S + 3);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_n.md
# pipe_ctrl_n

Parametrised pipeline sequencer for the 32-bit in-order core. It owns the inter-stage valid/payload registers for a configurable number of stages, detects load-use hazards, inserts bubbles and drives forwarding selects. It replaces the fixed, hand-wired five-stage chaining between the fetch front end and write-back with a single generic block that adds a global hold, branch flush and performance counters.

## Interface
Parameters:
- STAGES, 5, number of pipeline registers after fetch (stage 0 = decode … STAGES-1 = write-back); legal 3..8
- PAYLOAD_W, 32, opaque per-instruction payload width
- REG_AW, 5, register index width; index 0 is the hardwired zero register
- LOAD_SHADOW, 1, number of stages after stage 0 in which a load result is not yet forwardable; legal 1..STAGES-2
- FW, clog2(STAGES), width of forwarding select

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  instruction accepted this cycle when in_valid&&in_ready
- in_payload  in  PAYLOAD_W  instruction payload
- in_rs, in_rt, in_rd  in  REG_AW  source/destination indices
- in_wen  in  1  instruction writes in_rd
- in_is_load  in  1  instruction is a load
- flush  in  1  taken branch resolved in decode; kill stage 0
- hold  in  1  freeze all stages (memory wait)
- fwd_a, fwd_b  out  FW  forwarding source for stage 0 rs/rt: 0 = register file, k = stage k
- stage_valid  out  STAGES  per-stage valid bits
- out_valid  out  1  = stage_valid[STAGES-1]
- out_payload  out  PAYLOAD_W  stage STAGES-1 payload
- out_rd  out  REG_AW  stage STAGES-1 destination
- out_wen  out  1  out_valid && stage STAGES-1 wen
- stall_cnt  out  16  saturating count of load-use stall cycles
- flush_cnt  out  16  saturating count of killed instructions

## Operation
- Each stage k holds valid, payload, rs, rt, rd, wen, is_load.
- load_use = stage 0 valid && exists k in 1..LOAD_SHADOW: stage k valid && is_load && wen && rd!=0 && (rd==rs0 || rd==rt0).
- in_ready = !hold && !flush && !load_use (combinational).
- Priority per cycle: hold > flush > load_use > normal advance.
- hold: every stage register keeps its value, including stage 0; counters do not change. If flush is also high, stage 0 valid is still cleared (flush never lost) and flush_cnt updates.
- flush (no hold): stage 0 valid <= 0; stages 1..STAGES-1 shift normally; stage 1 receives stage 0 contents with valid forced 0. flush_cnt += 1 iff stage 0 was valid.
- load_use (no hold, no flush): stage 0 holds; stage 1 receives bubble (valid 0, wen 0); stages 2.. shift. stall_cnt += 1.
- Normal: stage k+1 <= stage k for all k; stage 0 <= input fields with valid = in_valid && in_ready.
- Forwarding: fwd_a = smallest k in LOAD_SHADOW+1..STAGES-1 with stage k valid && wen && rd!=0 && rd==rs0; else 0. Same for fwd_b with rt0. Loads in stages > LOAD_SHADOW are forwardable. Outputs 0 when stage 0 invalid.
- Counters saturate at 16'hFFFF.

## Timing
- Reset (async, reset=0): all valid bits, payloads, indices, counters = 0; in_ready reflects inputs combinationally (1 when hold/flush low).
- Deassertion of reset is sampled synchronously; first accept on first rising edge with reset=1.
- Latency: accepted instruction appears at out_valid exactly STAGES cycles later absent hold/stall.
- Each load-use stall adds 1 cycle per stall cycle; hold adds 1 cycle per held cycle.
- fwd_a/fwd_b, in_ready, out_* are valid in the same cycle as the registered state that produces them; no registered outputs besides stage state and counters.
- Reset asserted mid-operation discards all in-flight instructions immediately.

## Test plan
- Reset, then 8 back-to-back independent instructions (STAGES=5) -> out_valid first at cycle 5 after first accept, 8 consecutive outputs, stall_cnt=0.
- Load rd=3 followed by add rs=3 -> exactly one bubble in stage 1, in_ready low 1 cycle, stall_cnt=1, then fwd_a=2.
- add rd=4 then sub rs=4,rt=4 -> fwd_a=fwd_b=1 with LOAD_SHADOW=1 ... no wait: fwd from stage 2 only when k>LOAD_SHADOW; verify fwd_a=fwd_b=2 once dependent in stage 0 and producer in stage 2; rd=0 producer -> fwd 0.
- flush with valid stage 0 while load_use pending -> stage 0 killed, no bubble counted, flush_cnt=1, stall_cnt unchanged.
- hold high 3 cycles mid-stream with flush pulsed during hold -> all other stages frozen, stage 0 valid cleared, output sequence delayed exactly 3 cycles.
- Assert reset for 1 cycle with 4 instructions in flight -> all stage_valid=0 and counters 0 immediately; no stray out_wen afterwards.
